// File: rtl/t2mi_pkg.sv
// Shared T2-MI / MPEG-TS definitions used by the transport-stream front end.
package t2mi_pkg;

  localparam int         TS_PKT_LEN       = 188;
  localparam logic [7:0] TS_SYNC_BYTE     = 8'h47;
  localparam logic [7:0] TS_INV_SYNC_BYTE = 8'hB8;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } sync_state_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that holds at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  // Count single-cycle events, sticking at the maximum value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/ts_sync_aligner.sv
// MPEG-TS sync acquisition: hunts for the sync byte at the packet period,
// locks/unlocks with hysteresis and forwards only packet-aligned bytes with
// start/end markers. Define TS_INV_SYNC_EN to also accept the inverted sync
// byte (start of a DVB scrambling group) once hunting is over.
module ts_sync_aligner
  import t2mi_pkg::*;
#(
  parameter int         PKT_LEN      = TS_PKT_LEN,
  parameter logic [7:0] SYNC_BYTE    = TS_SYNC_BYTE,
  parameter int         LOCK_COUNT   = 3,
  parameter int         UNLOCK_COUNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resync,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_sync_err,
  output logic        sync_locked,
  output logic [15:0] sync_loss_count
);

  localparam int CNT_W  = $clog2(PKT_LEN);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PKT_LEN - 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK  = GOOD_W'(LOCK_COUNT);
  localparam logic [BAD_W-1:0]  BAD_UNLOCK = BAD_W'(UNLOCK_COUNT);

  sync_state_t       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [GOOD_W-1:0] good, good_nxt, good_inc;
  logic [BAD_W-1:0]  bad, bad_nxt, bad_inc;
  logic              at_sync;
  logic              match;
  logic              loss_evt;
  logic              fwd, fwd_sop, fwd_eop, fwd_err;

  // Sync check used once a candidate alignment exists (not in HUNT)
  function automatic logic sync_ok(input logic [7:0] b);
`ifdef TS_INV_SYNC_EN
    return (b == SYNC_BYTE) || (b == ~SYNC_BYTE);
`else
    return (b == SYNC_BYTE);
`endif
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_LAST) ? '0 : c + 1'b1;
  endfunction

  assign at_sync  = (cnt == '0);
  assign match    = sync_ok(in_data);
  assign good_inc = good + GOOD_W'(1);
  assign bad_inc  = bad + BAD_W'(1);

  // State and alignment counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_HUNT;
      cnt   <= '0;
      good  <= '0;
      bad   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      good  <= good_nxt;
      bad   <= bad_nxt;
    end
  end

  // Next state: resync wins over a coincident byte, which is then dropped
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    good_nxt  = good;
    bad_nxt   = bad;
    loss_evt  = 1'b0;
    if (resync) begin
      state_nxt = ST_HUNT;
      cnt_nxt   = '0;
      good_nxt  = '0;
      bad_nxt   = '0;
      loss_evt  = (state == ST_LOCKED);
    end else if (in_valid) begin
      case (state)
        ST_VERIFY: begin
          if (!at_sync) begin
            cnt_nxt = cnt_inc(cnt);
          end else if (match) begin
            cnt_nxt  = cnt_inc(cnt);
            good_nxt = good_inc;
            if (good_inc == GOOD_LOCK) begin
              state_nxt = ST_LOCKED;
              bad_nxt   = '0;
            end
          end else begin
            // The failing byte is not reconsidered as a new candidate
            state_nxt = ST_HUNT;
            cnt_nxt   = '0;
            good_nxt  = '0;
          end
        end
        ST_LOCKED: begin
          cnt_nxt = cnt_inc(cnt);
          if (at_sync) begin
            if (match) begin
              bad_nxt = '0;
            end else if (bad_inc == BAD_UNLOCK) begin
              state_nxt = ST_HUNT;
              cnt_nxt   = '0;
              good_nxt  = '0;
              bad_nxt   = '0;
              loss_evt  = 1'b1;
            end else begin
              bad_nxt = bad_inc;
            end
          end
        end
        default: begin
          // HUNT only ever trusts the true sync byte
          if (in_data == SYNC_BYTE) begin
            state_nxt = ST_VERIFY;
            cnt_nxt   = CNT_W'(1);
            good_nxt  = GOOD_W'(1);
          end
        end
      endcase
    end
  end

  // Forwarding decision and packet markers for the byte being accepted
  always_comb begin
    fwd     = 1'b0;
    fwd_sop = 1'b0;
    fwd_eop = 1'b0;
    fwd_err = 1'b0;
    if (!resync && in_valid) begin
      case (state)
        ST_VERIFY: begin
          if (at_sync && match && (good_inc == GOOD_LOCK)) begin
            fwd     = 1'b1;
            fwd_sop = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!at_sync) begin
            fwd     = 1'b1;
            fwd_eop = (cnt == CNT_LAST);
          end else if (match) begin
            fwd     = 1'b1;
            fwd_sop = 1'b1;
          end else if (bad_inc != BAD_UNLOCK) begin
            fwd     = 1'b1;
            fwd_sop = 1'b1;
            fwd_err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs, one cycle behind the accepted input byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_sync_err <= 1'b0;
      sync_locked  <= 1'b0;
    end else begin
      out_valid    <= fwd;
      out_sop      <= fwd_sop;
      out_eop      <= fwd_eop;
      out_sync_err <= fwd_err;
      sync_locked  <= (state_nxt == ST_LOCKED);
      if (fwd) begin
        out_data <= in_data;
      end
    end
  end

  sat_counter16 u_loss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (loss_evt),
    .count (sync_loss_count)
  );

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Scoreboard bench for ts_sync_aligner: a packet-level reference model
// predicts every forwarded byte plus lock status and loss count.
`timescale 1ns/1ps
module tb_ts_sync_aligner;

  localparam int         PKT_LEN      = 188;
  localparam int         LOCK_COUNT   = 3;
  localparam int         UNLOCK_COUNT = 3;
  localparam logic [7:0] SYNC         = 8'h47;
  localparam logic [7:0] INV          = 8'hB8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        resync = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_sync_err;
  logic        sync_locked;
  logic [15:0] sync_loss_count;

  always #5 clk = ~clk;

  ts_sync_aligner dut (
    .clk             (clk),
    .rst             (rst),
    .resync          (resync),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_sop         (out_sop),
    .out_eop         (out_eop),
    .out_sync_err    (out_sync_err),
    .sync_locked     (sync_locked),
    .sync_loss_count (sync_loss_count)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       err;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;

  int vectors = 0;
  int miscompares = 0;

  // reference model: alignment described as "position within the packet"
  bit m_locked = 0;
  bit m_verifying = 0;
  int m_pos = 0;
  int m_good = 0;
  int m_bad = 0;
  int m_loss = 0;

  int sop_seen = 0;
  int eop_seen = 0;
  int err_seen = 0;
  int since_sop = 0;

  function automatic bit sync_good(input logic [7:0] b);
`ifdef TS_INV_SYNC_EN
    return (b == SYNC) || (b == INV);
`else
    return (b == SYNC);
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input bit sop, input bit eop, input bit err);
    beat_t b;
    b.data = d;
    b.sop  = sop;
    b.eop  = eop;
    b.err  = err;
    exp_q.push_back(b);
  endtask

  task automatic model_clear();
    m_locked    = 0;
    m_verifying = 0;
    m_pos       = 0;
    m_good      = 0;
    m_bad       = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit rs);
    if (rs) begin
      if (m_locked && m_loss < 65535) m_loss++;
      model_clear();
    end else if (v) begin
      if (m_locked) begin
        if (m_pos == 0 && !sync_good(d)) begin
          m_bad++;
          if (m_bad == UNLOCK_COUNT) begin
            if (m_loss < 65535) m_loss++;
            model_clear();
          end else begin
            push(d, 1, 0, 1);
            m_pos = 1;
          end
        end else begin
          if (m_pos == 0) m_bad = 0;
          push(d, m_pos == 0, m_pos == PKT_LEN - 1, 0);
          m_pos = (m_pos + 1) % PKT_LEN;
        end
      end else if (m_verifying) begin
        if (m_pos != 0) begin
          m_pos = (m_pos + 1) % PKT_LEN;
        end else if (sync_good(d)) begin
          m_good++;
          m_pos = 1;
          if (m_good == LOCK_COUNT) begin
            m_locked    = 1;
            m_verifying = 0;
            m_bad       = 0;
            push(d, 1, 0, 0);
          end
        end else begin
          model_clear();
        end
      end else if (d == SYNC) begin
        m_verifying = 1;
        m_pos       = 1;
        m_good      = 1;
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit rs);
    in_valid = v;
    in_data  = d;
    resync   = rs;
    @(posedge clk);
    model_step(v, d, rs);
    #1;
  endtask

  // gap_mode: 0 continuous, 1 idle cycle before every byte, 2 random idles
  task automatic send_pkt(input logic [7:0] sync_b, input bit rnd, input int gap_mode);
    for (int i = 0; i < PKT_LEN; i++) begin
      if (gap_mode == 1) step(0, 8'h00, 0);
      else if (gap_mode == 2 && $urandom_range(3) == 0) step(0, 8'($urandom), 0);
      step(1, (i == 0) ? sync_b : (rnd ? 8'($urandom) : 8'h00), 0);
    end
  endtask

  task automatic apply_reset();
    in_valid = 0;
    resync   = 0;
    in_data  = 8'h00;
    rst      = 1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sop", out_sop, 0);
    check("rst_out_eop", out_eop, 0);
    check("rst_out_sync_err", out_sync_err, 0);
    check("rst_sync_locked", sync_locked, 0);
    check("rst_sync_loss_count", sync_loss_count, 0);
    model_clear();
    m_loss = 0;
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Monitor: pop and compare every presented byte, track lock status each cycle
  always @(negedge clk) begin
    if (!rst) begin
      check("sync_locked", sync_locked, m_locked);
      check("sync_loss_count", sync_loss_count, m_loss);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_sop", out_sop, mon_e.sop);
          check("out_eop", out_eop, mon_e.eop);
          check("out_sync_err", out_sync_err, mon_e.err);
        end
        if (out_sop) begin
          sop_seen++;
          since_sop = 0;
        end else begin
          since_sop++;
        end
        if (out_sync_err) err_seen++;
        if (out_eop) begin
          eop_seen++;
          check("eop_distance", since_sop, PKT_LEN - 1);
        end
      end
    end
  end

  int err0;
  int exp_inv_errs;

  initial begin
    #2;
    apply_reset();

    // clean stream: lock on the third sync, three full packets out
    for (int p = 0; p < 5; p++) send_pkt(SYNC, 0, 0);
    step(0, 8'h00, 0);
    check("p1_sop_count", sop_seen, 3);
    check("p1_eop_count", eop_seen, 3);
    check("p1_locked", sync_locked, 1);

    // random lead-in, then a gappy clean stream
    apply_reset();
    for (int i = 0; i < 10; i++) step(1, 8'($urandom), 0);
    for (int p = 0; p < 6; p++) send_pkt(SYNC, 0, 1);
    step(0, 8'h00, 0);
    check("p2_locked", sync_locked, 1);

    // one corrupted sync while locked
    apply_reset();
    for (int p = 0; p < 4; p++) send_pkt(SYNC, 1, 0);
    err0 = err_seen;
    send_pkt(8'h46, 1, 0);
    send_pkt(SYNC, 1, 0);
    check("p3_err_count", err_seen - err0, 1);
    check("p3_locked", sync_locked, 1);
    check("p3_loss", sync_loss_count, 0);

    // three corrupted syncs in a row drop lock, then relock
    send_pkt(8'h46, 0, 0);
    send_pkt(8'h12, 0, 0);
    send_pkt(8'h46, 0, 0);
    check("p4_unlocked", sync_locked, 0);
    check("p4_loss", sync_loss_count, 1);
    for (int p = 0; p < 3; p++) send_pkt(SYNC, 0, 0);
    step(0, 8'h00, 0);
    check("p4_relocked", sync_locked, 1);

    // resync mid-packet while locked, then resync while hunting
    for (int i = 0; i < 60; i++) step(1, (i == 0) ? SYNC : 8'($urandom), 0);
    step(1, 8'hAA, 1);
    step(0, 8'h00, 0);
    check("p5_unlocked", sync_locked, 0);
    check("p5_loss", sync_loss_count, 2);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    check("p5_loss_hunt", sync_loss_count, 2);

    // every 8th sync inverted
    err0 = err_seen;
    for (int p = 1; p <= 16; p++) send_pkt((p % 8 == 0) ? INV : SYNC, 1, 0);
    step(0, 8'h00, 0);
`ifdef TS_INV_SYNC_EN
    exp_inv_errs = 0;
`else
    exp_inv_errs = 2;
`endif
    check("p6_inv_err_count", err_seen - err0, exp_inv_errs);
    check("p6_locked", sync_locked, 1);

    // randomized traffic: mixed syncs, gaps and resync pulses
    for (int p = 0; p < 30; p++) begin
      int r;
      logic [7:0] sb;
      r = $urandom_range(9);
      sb = (r < 7) ? SYNC : ((r == 7) ? INV : 8'($urandom));
      send_pkt(sb, 1, 2);
      if ($urandom_range(7) == 0) step(1, 8'($urandom), 1);
    end

    // asynchronous reset in the middle of a forwarded packet
    for (int p = 0; p < 4; p++) send_pkt(SYNC, 0, 0);
    for (int i = 0; i < 50; i++) step(1, (i == 0) ? SYNC : 8'h00, 0);
    check("pre_reset_out_valid", out_valid, 1);
    apply_reset();
    for (int p = 0; p < 4; p++) send_pkt(SYNC, 1, 2);

    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
